// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT defaults, stage phase type and width-reduction helper
package fft_pkg;
  localparam int DATA_W_DEF  = 19;
  localparam int TW_W_DEF    = 10;
  localparam int TW_FRAC_DEF = 8;
  typedef enum logic {FILL = 1'b0, BFLY = 1'b1} phase_e;
  // Reduce x to w signed bits: clamp to the w-bit range or keep the low w bits (sign-extended back).
  function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] x, input int unsigned w, input logic sat);
    logic signed [63:0] mx, mn, wr;
    mx = (64'sd1 <<< (w - 1)) - 64'sd1;
    mn = -mx - 64'sd1;
    wr = (x <<< (64 - w)) >>> (64 - w);
    return sat ? (x > mx ? mx : x < mn ? mn : x) : wr;
  endfunction
endpackage

// File: rtl/cmul_round.sv
// cmul_round: complex multiply by twiddle with optional conjugate, rounding, shift and saturate/wrap
// Ports: i_ar/i_ai data in, i_wr/i_wi twiddle in, i_conj negates i_wi, o_pr/o_pi product out.
module cmul_round import fft_pkg::*; #(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TW_W    = TW_W_DEF,
  parameter int TW_FRAC = TW_FRAC_DEF,
  parameter int ROUND   = 1,
  parameter int SAT     = 1
) (
  input  logic signed [DATA_W-1:0] i_ar,
  input  logic signed [DATA_W-1:0] i_ai,
  input  logic signed [TW_W-1:0]   i_wr,
  input  logic signed [TW_W-1:0]   i_wi,
  input  logic                     i_conj,
  output logic signed [DATA_W-1:0] o_pr,
  output logic signed [DATA_W-1:0] o_pi
);
  localparam int PW = DATA_W + TW_W + 1;
  localparam logic signed [PW-1:0] RND = ROUND != 0 ? PW'(1) <<< (TW_FRAC - 1) : '0;
  logic signed [PW-1:0] w_ar, w_ai, w_wr, w_wi, w_pr, w_pi, w_sr, w_si;
  assign w_ar = PW'(i_ar);
  assign w_ai = PW'(i_ai);
  assign w_wr = PW'(i_wr);
  // Widened before negation so the most negative twiddle conjugates without overflow.
  assign w_wi = i_conj ? -PW'(i_wi) : PW'(i_wi);
  assign w_pr = w_ar * w_wr - w_ai * w_wi + RND;
  assign w_pi = w_ar * w_wi + w_ai * w_wr + RND;
  assign w_sr = w_pr >>> TW_FRAC;
  assign w_si = w_pi >>> TW_FRAC;
  assign o_pr = DATA_W'(sat_trunc(64'(w_sr), DATA_W, SAT != 0));
  assign o_pi = DATA_W'(sat_trunc(64'(w_si), DATA_W, SAT != 0));
endmodule

// File: rtl/r2sdf_stage.sv
// r2sdf_stage: radix-2 single-path delay-feedback FFT stage (butterfly, feedback delay, twiddle sequencing)
// Ports: clk/rst (async high); valid_i/inv_i/din_r/din_i sample in; tw_idx out to twiddle ROM,
// tw_r/tw_i back from it; valid_o/dout_r/dout_i registered result one cycle after each accepted sample.
module r2sdf_stage import fft_pkg::*; #(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TW_W    = TW_W_DEF,
  parameter int TW_FRAC = TW_FRAC_DEF,
  parameter int DELAY   = 16,
  parameter int ROUND   = 1,
  parameter int SAT     = 1,
  localparam int TIW    = DELAY > 1 ? $clog2(DELAY) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_i,
  input  logic                     inv_i,
  input  logic signed [DATA_W-1:0] din_r,
  input  logic signed [DATA_W-1:0] din_i,
  output logic [TIW-1:0]           tw_idx,
  input  logic signed [TW_W-1:0]   tw_r,
  input  logic signed [TW_W-1:0]   tw_i,
  output logic                     valid_o,
  output logic signed [DATA_W-1:0] dout_r,
  output logic signed [DATA_W-1:0] dout_i
);
  localparam int CW = $clog2(DELAY) + 1;
  logic [CW-1:0] r_cnt;
  logic r_primed, r_inv;
  logic signed [DATA_W-1:0] r_dl_r [DELAY];
  logic signed [DATA_W-1:0] r_dl_i [DELAY];
  logic signed [DATA_W:0] w_sw_r, w_sw_i, w_dw_r, w_dw_i;
  logic signed [DATA_W-1:0] w_hr, w_hi, w_pr, w_pi, w_sum_r, w_sum_i, w_dif_r, w_dif_i;
  logic w_fill, w_inv, w_ov;
  assign w_fill = phase_e'(r_cnt[CW-1]) == FILL;
  assign w_hr = r_dl_r[DELAY-1];
  assign w_hi = r_dl_i[DELAY-1];
  // The frame-start sample already uses the direction being latched for its frame.
  assign w_inv = r_cnt == '0 ? inv_i : r_inv;
  assign w_ov = valid_i & (!w_fill | r_primed);
  assign tw_idx = w_fill ? r_cnt[TIW-1:0] : '0;
  assign w_sw_r = (DATA_W+1)'(w_hr) + (DATA_W+1)'(din_r);
  assign w_sw_i = (DATA_W+1)'(w_hi) + (DATA_W+1)'(din_i);
  assign w_dw_r = (DATA_W+1)'(w_hr) - (DATA_W+1)'(din_r);
  assign w_dw_i = (DATA_W+1)'(w_hi) - (DATA_W+1)'(din_i);
  assign w_sum_r = DATA_W'(sat_trunc(64'(w_sw_r), DATA_W, SAT != 0));
  assign w_sum_i = DATA_W'(sat_trunc(64'(w_sw_i), DATA_W, SAT != 0));
  assign w_dif_r = DATA_W'(sat_trunc(64'(w_dw_r), DATA_W, SAT != 0));
  assign w_dif_i = DATA_W'(sat_trunc(64'(w_dw_i), DATA_W, SAT != 0));
  cmul_round #(
    .DATA_W(DATA_W), .TW_W(TW_W), .TW_FRAC(TW_FRAC), .ROUND(ROUND), .SAT(SAT)
  ) u_cmul (
    .i_ar(w_hr), .i_ai(w_hi), .i_wr(tw_r), .i_wi(tw_i), .i_conj(w_inv),
    .o_pr(w_pr), .o_pi(w_pi)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_primed <= 1'b0;
      r_inv    <= 1'b0;
      valid_o  <= 1'b0;
      dout_r   <= '0;
      dout_i   <= '0;
    end else begin
      valid_o <= w_ov;
      if (valid_i) begin
        r_cnt    <= r_cnt + CW'(1);
        r_primed <= r_primed | !w_fill;
        r_inv    <= w_inv;
      end
      if (w_ov) begin
        dout_r <= w_fill ? w_pr : w_sum_r;
        dout_i <= w_fill ? w_pi : w_sum_i;
      end
    end
  end
  // Contents are never reset; stale words only reach the output before primed is set.
  always_ff @(posedge clk) begin
    if (valid_i) begin
      r_dl_r[0] <= w_fill ? din_r : w_dif_r;
      r_dl_i[0] <= w_fill ? din_i : w_dif_i;
      for (int j = 1; j < DELAY; j++) begin
        r_dl_r[j] <= r_dl_r[j-1];
        r_dl_i[j] <= r_dl_i[j-1];
      end
    end
  end
endmodule

// File: tb/tb_r2sdf_stage.sv
// tb_r2sdf_stage: directed scoreboard bench for two DELAY=2 stages (round+saturate and truncate+wrap)
module tb_r2sdf_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid_i = 1'b0;
  logic inv_i = 1'b0;
  logic signed [18:0] din_r = '0;
  logic signed [18:0] din_i = '0;
  logic signed [9:0] tw_r = '0;
  logic signed [9:0] tw_i = '0;
  logic [0:0] idx0, idx1;
  logic v0, v1;
  logic signed [18:0] r0, i0, r1, i1;
  typedef struct {bit ev; int er0; int ei0; int er1; int ei1;} exp_t;
  exp_t q[$];
  int n_vec = 0, n_err = 0, cnt = 0;
  int l0r = 0, l0i = 0, l1r = 0, l1i = 0;
  always #5 clk = ~clk;
  r2sdf_stage #(.DELAY(2), .ROUND(1), .SAT(1)) u0 (
    .clk(clk), .rst(rst), .valid_i(valid_i), .inv_i(inv_i), .din_r(din_r), .din_i(din_i),
    .tw_idx(idx0), .tw_r(tw_r), .tw_i(tw_i), .valid_o(v0), .dout_r(r0), .dout_i(i0)
  );
  r2sdf_stage #(.DELAY(2), .ROUND(0), .SAT(0)) u1 (
    .clk(clk), .rst(rst), .valid_i(valid_i), .inv_i(inv_i), .din_r(din_r), .din_i(din_i),
    .tw_idx(idx1), .tw_r(tw_r), .tw_i(tw_i), .valid_o(v1), .dout_r(r1), .dout_i(i1)
  );
  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic chk_out(input string sfx);
    chk({"dr0_", sfx}, r0, l0r);
    chk({"di0_", sfx}, i0, l0i);
    chk({"dr1_", sfx}, r1, l1r);
    chk({"di1_", sfx}, i1, l1i);
  endtask
  task automatic chk_idx(input string tag);
    chk({tag, "0"}, idx0, cnt < 2 ? cnt : 0);
    chk({tag, "1"}, idx1, cnt < 2 ? cnt : 0);
  endtask
  task automatic idle();
    valid_i = 1'b0;
    @(posedge clk);
    #1;
    chk("vo0_stall", v0, 0);
    chk("vo1_stall", v1, 0);
    chk_out("stall");
    chk_idx("tw_idx_stall");
  endtask
  task automatic smp(input int dr, input bit inv, input bit ev, input int a_r, input int a_i, input int b_r, input int b_i);
    exp_t e;
    repeat ($urandom_range(0, 2)) idle();
    valid_i = 1'b1;
    din_r = 19'(dr);
    inv_i = inv;
    #1;
    chk_idx("tw_idx");
    e = '{ev, a_r, a_i, b_r, b_i};
    q.push_back(e);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    cnt = (cnt + 1) % 4;
    e = q.pop_front();
    chk("vo0", v0, 32'(e.ev));
    chk("vo1", v1, 32'(e.ev));
    if (e.ev) begin
      l0r = e.er0; l0i = e.ei0; l1r = e.er1; l1i = e.ei1;
    end
    chk_out("out");
  endtask
  task automatic do_reset();
    valid_i = 1'b0;
    rst = 1'b1;
    #1;
    l0r = 0; l0i = 0; l1r = 0; l1i = 0;
    cnt = 0;
    chk("vo0_rst", v0, 0);
    chk("vo1_rst", v1, 0);
    chk_out("rst");
    chk_idx("tw_idx_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  initial begin
    do_reset();
    tw_r = 10'sd256; tw_i = 10'sd0;
    smp(1, 0, 0, 0, 0, 0, 0);
    smp(2, 0, 0, 0, 0, 0, 0);
    smp(3, 0, 1, 4, 0, 4, 0);
    smp(4, 0, 1, 6, 0, 6, 0);
    smp(262143, 0, 1, -2, 0, -2, 0);
    smp(262143, 0, 1, -2, 0, -2, 0);
    smp(262143, 0, 1, 262143, 0, -2, 0);
    smp(262143, 0, 1, 262143, 0, -2, 0);
    tw_r = 10'sd128;
    smp(3, 0, 1, 0, 0, 0, 0);
    smp(3, 0, 1, 0, 0, 0, 0);
    smp(0, 0, 1, 3, 0, 3, 0);
    smp(0, 0, 1, 3, 0, 3, 0);
    smp(1, 0, 1, 2, 0, 1, 0);
    smp(1, 0, 1, 2, 0, 1, 0);
    smp(0, 0, 1, 1, 0, 1, 0);
    smp(0, 0, 1, 1, 0, 1, 0);
    tw_r = 10'sd0; tw_i = 10'sd256;
    smp(1, 0, 1, 0, 1, 0, 1);
    smp(1, 1, 1, 0, 1, 0, 1);
    smp(0, 1, 1, 1, 0, 1, 0);
    smp(0, 1, 1, 1, 0, 1, 0);
    smp(0, 1, 1, 0, -1, 0, -1);
    smp(0, 0, 1, 0, -1, 0, -1);
    smp(0, 0, 1, 0, 0, 0, 0);
    smp(0, 0, 1, 0, 0, 0, 0);
    tw_r = 10'sd256; tw_i = 10'sd0;
    smp(9, 0, 1, 0, 0, 0, 0);
    smp(9, 0, 1, 0, 0, 0, 0);
    smp(9, 0, 1, 18, 0, 18, 0);
    do_reset();
    smp(5, 0, 0, 0, 0, 0, 0);
    smp(6, 0, 0, 0, 0, 0, 0);
    smp(7, 0, 1, 12, 0, 12, 0);
    smp(8, 0, 1, 14, 0, 14, 0);
    smp(0, 0, 1, -2, 0, -2, 0);
    smp(0, 0, 1, -2, 0, -2, 0);
    idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
